// File: rtl/control_unit_if.sv
// Status/control bundle between the accumulator-processor controller and its datapath.
// The controller takes the master modport; the datapath (or a bench) takes slave.
interface control_unit_if #(parameter int COUNT_W = 8);
    logic [2:0]         IR;
    logic               Aeq0;
    logic               Apos;
    logic               Enter;
    logic               IRload;
    logic               PCload;
    logic               Aload;
    logic               MemWr;
    logic               JMPmux;
    logic               Meminst;
    logic               Sub;
    logic [1:0]         Asel;
    logic               Initialize;
    logic               Halt;
    logic               InWait;
    logic [2:0]         State;
    logic [COUNT_W-1:0] InstrCount;

    modport master (
        input  IR, Aeq0, Apos, Enter,
        output IRload, PCload, Aload, MemWr, JMPmux, Meminst, Sub, Asel,
               Initialize, Halt, InWait, State, InstrCount
    );

    modport slave (
        output IR, Aeq0, Apos, Enter,
        input  IRload, PCload, Aload, MemWr, JMPmux, Meminst, Sub, Asel,
               Initialize, Halt, InWait, State, InstrCount
    );
endinterface

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator processor.
// Define CU_INPUT_HANDSHAKE_EN to make IN wait for the operator Enter strobe.
module control_unit #(
    parameter int COUNT_W = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    control_unit_if.master bus
);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_IN_WAIT = 3'd4,
        S_IN_REL  = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_IN    = 3'b100,
        OP_JZ    = 3'b101,
        OP_JPOS  = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    state_t             state;
    state_t             next_state;
    logic [COUNT_W-1:0] instr_count;

`ifndef CU_INPUT_HANDSHAKE_EN
    logic unused_enter;
    assign unused_enter = bus.Enter;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= S_INIT;
            instr_count <= '0;
        end else begin
            state <= next_state;
            if (state == S_FETCH)
                instr_count <= instr_count + COUNT_W'(1);
        end
    end

    assign bus.State      = state;
    assign bus.InstrCount = instr_count;

    // Outputs decode from the state; the jump and Enter terms are Mealy.
    always_comb begin
        next_state     = S_INIT;
        bus.IRload     = 1'b0;
        bus.PCload     = 1'b0;
        bus.Aload      = 1'b0;
        bus.MemWr      = 1'b0;
        bus.JMPmux     = 1'b0;
        bus.Meminst    = 1'b0;
        bus.Sub        = 1'b0;
        bus.Asel       = 2'b00;
        bus.Initialize = 1'b0;
        bus.Halt       = 1'b0;
        bus.InWait     = 1'b0;

        case (state)
            S_INIT: begin
                bus.Initialize = 1'b1;
                next_state     = S_FETCH;
            end
            S_FETCH: begin
                bus.IRload = 1'b1;
                bus.PCload = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                bus.Meminst = 1'b1;
                if (bus.IR == OP_HALT)
                    next_state = S_HALT;
`ifdef CU_INPUT_HANDSHAKE_EN
                else if (bus.IR == OP_IN)
                    next_state = S_IN_WAIT;
`endif
                else
                    next_state = S_EXEC;
            end
            S_EXEC: begin
                bus.Meminst = 1'b1;
                next_state  = S_FETCH;
                case (bus.IR)
                    OP_LOAD: begin
                        bus.Asel  = 2'b10;
                        bus.Aload = 1'b1;
                    end
                    OP_STORE: bus.MemWr = 1'b1;
                    OP_ADD:   bus.Aload = 1'b1;
                    OP_SUB: begin
                        bus.Sub   = 1'b1;
                        bus.Aload = 1'b1;
                    end
`ifndef CU_INPUT_HANDSHAKE_EN
                    OP_IN: begin
                        bus.Asel  = 2'b01;
                        bus.Aload = 1'b1;
                    end
`endif
                    OP_JZ: begin
                        bus.JMPmux = 1'b1;
                        bus.PCload = bus.Aeq0;
                    end
                    OP_JPOS: begin
                        bus.JMPmux = 1'b1;
                        bus.PCload = bus.Apos;
                    end
                    default: ;
                endcase
            end
`ifdef CU_INPUT_HANDSHAKE_EN
            S_IN_WAIT: begin
                bus.InWait = 1'b1;
                next_state = S_IN_WAIT;
                if (bus.Enter) begin
                    bus.Asel   = 2'b01;
                    bus.Aload  = 1'b1;
                    next_state = S_IN_REL;
                end
            end
            S_IN_REL: begin
                next_state = bus.Enter ? S_IN_REL : S_FETCH;
            end
`endif
            S_HALT: begin
                bus.Halt   = 1'b1;
                next_state = S_HALT;
            end
            default: next_state = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: an instruction-level model expands each
// instruction into its expected per-cycle outputs, which the driver replays and checks.
module tb_control_unit;

    typedef struct packed {
        logic       irload;
        logic       pcload;
        logic       aload;
        logic       memwr;
        logic       jmpmux;
        logic       meminst;
        logic       sub;
        logic [1:0] asel;
        logic       initialize;
        logic       halt;
        logic       inwait;
        logic [2:0] state;
    } outs_t;

    typedef struct packed {
        logic [2:0] ir;
        logic       aeq0;
        logic       apos;
        logic       enter;
        logic       rst;
        outs_t      exp;
        logic [7:0] cnt;
    } rec_t;

`ifdef CU_INPUT_HANDSHAKE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic   clk;
    logic   rst;
    rec_t   recs[$];
    string  tags[$];
    logic [7:0] m_count;
    int     tests;
    int     fails;

    control_unit_if #(.COUNT_W(8)) bus ();

    control_unit #(.COUNT_W(8)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t st(input logic [2:0] s);
        outs_t o;
        o       = '0;
        o.state = s;
        return o;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // The counter seen in a cycle is the number of FETCH cycles completed since reset.
    task automatic push(input string tag, input logic [2:0] ir, input logic aeq0, input logic apos,
                        input logic enter, input logic r, input outs_t exp);
        rec_t rc;
        rc.ir    = ir;
        rc.aeq0  = aeq0;
        rc.apos  = apos;
        rc.enter = enter;
        rc.rst   = r;
        rc.exp   = exp;
        rc.cnt   = m_count;
        recs.push_back(rc);
        tags.push_back(tag);
        if (r)
            m_count = 8'd0;
        else if (exp.state == 3'd1)
            m_count = m_count + 8'd1;
    endtask

    task automatic push_init();
        push("init", 3'($urandom), rbit(), rbit(), rbit(), 1'b0, '{initialize: 1'b1, state: 3'd0, default: '0});
    endtask

    task automatic push_front(input logic [2:0] op);
        outs_t o;
        o = st(3'd1);
        o.irload = 1'b1;
        o.pcload = 1'b1;
        push("fetch", op, rbit(), rbit(), rbit(), 1'b0, o);
        o = st(3'd2);
        o.meminst = 1'b1;
        push("decode", op, rbit(), rbit(), HS ? 1'b0 : rbit(), 1'b0, o);
    endtask

    task automatic push_halt(input int n);
        for (int k = 0; k < n; k++)
            push("halt", 3'd7, rbit(), rbit(), rbit(), (k == n - 1), '{halt: 1'b1, state: 3'd6, default: '0});
        push_init();
    endtask

    // One full instruction; aeq0/apos feed EXEC, low_n/high_n shape the Enter pulse for IN.
    task automatic push_instr(input logic [2:0] op, input logic aeq0, input logic apos,
                              input int low_n, input int high_n);
        outs_t o;
        push_front(op);
        if (op == 3'd7) begin
            push_halt(20);
        end else if (op == 3'd4 && HS) begin
            for (int k = 0; k < low_n; k++)
                push("in_wait", op, rbit(), rbit(), 1'b0, 1'b0, '{inwait: 1'b1, state: 3'd4, default: '0});
            o = st(3'd4);
            o.inwait = 1'b1;
            o.asel   = 2'b01;
            o.aload  = 1'b1;
            push("in_accept", op, rbit(), rbit(), 1'b1, 1'b0, o);
            for (int k = 1; k < high_n; k++)
                push("in_rel_hold", op, rbit(), rbit(), 1'b1, 1'b0, st(3'd5));
            push("in_rel_done", op, rbit(), rbit(), 1'b0, 1'b0, st(3'd5));
        end else begin
            o = st(3'd3);
            o.meminst = 1'b1;
            case (op)
                3'd0: begin o.asel = 2'b10; o.aload = 1'b1; end
                3'd1: o.memwr = 1'b1;
                3'd2: o.aload = 1'b1;
                3'd3: begin o.sub = 1'b1; o.aload = 1'b1; end
                3'd4: begin o.asel = 2'b01; o.aload = 1'b1; end
                3'd5: begin o.jmpmux = 1'b1; o.pcload = aeq0; end
                default: begin o.jmpmux = 1'b1; o.pcload = apos; end
            endcase
            push("exec", op, aeq0, apos, rbit(), 1'b0, o);
        end
    endtask

    // Reset arrives while an IN is pending (or mid-EXEC of IN without the handshake).
    task automatic push_abort();
        outs_t o;
        push_front(3'd4);
        if (HS) begin
            push("abort_wait", 3'd4, rbit(), rbit(), 1'b0, 1'b0, '{inwait: 1'b1, state: 3'd4, default: '0});
            push("abort_rst", 3'd4, rbit(), rbit(), 1'b0, 1'b1, '{inwait: 1'b1, state: 3'd4, default: '0});
        end else begin
            o = st(3'd3);
            o.meminst = 1'b1;
            o.asel    = 2'b01;
            o.aload   = 1'b1;
            push("abort_rst", 3'd4, rbit(), rbit(), rbit(), 1'b1, o);
        end
        push_init();
    endtask

    initial begin
        outs_t obs;
        tests       = 0;
        fails       = 0;
        m_count     = 8'd0;
        rst         = 1'b1;
        bus.IR      = 3'd0;
        bus.Aeq0    = 1'b0;
        bus.Apos    = 1'b0;
        bus.Enter   = 1'b0;

        for (int k = 0; k < 3; k++)
            push("reset", 3'($urandom), rbit(), rbit(), rbit(), 1'b1, '{initialize: 1'b1, state: 3'd0, default: '0});
        push_init();
        push_instr(3'd0, rbit(), rbit(), 0, 1);
        push_instr(3'd1, rbit(), rbit(), 0, 1);
        push_instr(3'd2, rbit(), rbit(), 0, 1);
        push_instr(3'd3, rbit(), rbit(), 0, 1);
        push_instr(3'd5, 1'b1, rbit(), 0, 1);
        push_instr(3'd5, 1'b0, rbit(), 0, 1);
        push_instr(3'd6, rbit(), 1'b0, 0, 1);
        push_instr(3'd6, rbit(), 1'b1, 0, 1);
        push_instr(3'd4, rbit(), rbit(), 4, 3);
        push_instr(3'd4, rbit(), rbit(), 0, 1);
        push_abort();
        for (int k = 0; k < 40; k++)
            push_instr(3'($urandom_range(0, 6)), rbit(), rbit(), $urandom_range(0, 3), $urandom_range(1, 3));
        push_instr(3'd7, rbit(), rbit(), 0, 1);
        for (int k = 0; k < 256; k++)
            push_instr(3'd0, rbit(), rbit(), 0, 1);
        push_instr(3'd0, rbit(), rbit(), 0, 1);

        @(posedge clk);
        foreach (recs[i]) begin
            @(negedge clk);
            bus.IR    = recs[i].ir;
            bus.Aeq0  = recs[i].aeq0;
            bus.Apos  = recs[i].apos;
            bus.Enter = recs[i].enter;
            rst       = recs[i].rst;
            #1;
            obs = {bus.IRload, bus.PCload, bus.Aload, bus.MemWr, bus.JMPmux, bus.Meminst, bus.Sub,
                   bus.Asel, bus.Initialize, bus.Halt, bus.InWait, bus.State};
            tests++;
            assert (obs === recs[i].exp) else begin
                fails++;
                $error("FAIL %s[%0d] outputs observed=%h expected=%h", tags[i], i, obs, recs[i].exp);
            end
            tests++;
            assert (bus.InstrCount === recs[i].cnt) else begin
                fails++;
                $error("FAIL %s[%0d] InstrCount observed=%0d expected=%0d", tags[i], i, bus.InstrCount, recs[i].cnt);
            end
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
